// File: rtl/rv_inst_encoder.sv
// rv_inst_encoder: packs decoded RV32I fields into a 32-bit machine word and
// streams it as two 16-bit parcels (low first). Illegal requests are accepted,
// dropped, flagged for one cycle and counted in a saturating counter.
module rv_inst_encoder #(
    parameter int ERR_COUNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_op,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [31:0]                in_imm,
    input  logic [3:0]                 in_pred,
    input  logic [3:0]                 in_succ,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_parcel,
    output logic                       out_last,
    output logic                       err_valid,
    output logic [ERR_COUNT_WIDTH-1:0] err_count
);

    // Operation codes, in rv_inst::rv_inst_32i order.
    typedef enum logic [7:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_FENCE_I, OP_ECALL, OP_EBREAK,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
        OP_UNDEF
    } op_e;

    typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_RAW} fmt_e;
    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_e;

    op_e    op;
    fmt_e   fmt;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] raw;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        fits12, fits13, fits21;

    state_e state_q, state_d;
    logic [31:0]                word_q;
    logic                       err_q;
    logic [ERR_COUNT_WIDTH-1:0] cnt_q;
    logic                       acc;

    assign op     = op_e'(in_op);
    assign fits12 = (in_imm[31:11] == {21{in_imm[11]}});
    assign fits13 = (in_imm[31:12] == {20{in_imm[12]}});
    assign fits21 = (in_imm[31:20] == {12{in_imm[20]}});

    // Format, major opcode and immediate legality per operation.
    always_comb begin
        fmt       = F_RAW;
        opc       = 7'b0;
        raw       = 32'b0;
        enc_legal = 1'b1;
        case (op)
            OP_LUI:   begin fmt = F_U; opc = 7'b0110111; enc_legal = (in_imm[11:0] == 12'd0); end
            OP_AUIPC: begin fmt = F_U; opc = 7'b0010111; enc_legal = (in_imm[11:0] == 12'd0); end
            OP_JAL:   begin fmt = F_J; opc = 7'b1101111; enc_legal = fits21 && !in_imm[0]; end
            OP_JALR:  begin fmt = F_I; opc = 7'b1100111; enc_legal = fits12; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
                begin fmt = F_B; opc = 7'b1100011; enc_legal = fits13 && !in_imm[0]; end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
                begin fmt = F_I; opc = 7'b0000011; enc_legal = fits12; end
            OP_SB, OP_SH, OP_SW:
                begin fmt = F_S; opc = 7'b0100011; enc_legal = fits12; end
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI:
                begin fmt = F_I; opc = 7'b0010011; enc_legal = fits12; end
            OP_SLLI, OP_SRLI, OP_SRAI:
                begin fmt = F_SH; opc = 7'b0010011; enc_legal = (in_imm[31:5] == 27'd0); end
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND:
                begin fmt = F_R; opc = 7'b0110011; end
            OP_FENCE:  raw = {4'b0, in_pred, in_succ, 5'b0, 3'b000, 5'b0, 7'b0001111};
            OP_FENCE_I: raw = 32'h0000100F;
            OP_ECALL:  raw = 32'h00000073;
            OP_EBREAK: raw = 32'h00100073;
            OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI:
                begin fmt = F_I; opc = 7'b1110011; enc_legal = (in_imm[31:12] == 20'd0); end
            default:   enc_legal = 1'b0;
        endcase
    end

    // funct3 / funct7 selection, grouped by value.
    always_comb begin
        f3 = 3'b000;
        f7 = 7'b0000000;
        case (op)
            OP_BNE, OP_LH, OP_SH, OP_SLLI, OP_SLL, OP_CSRRW:           f3 = 3'b001;
            OP_LW, OP_SW, OP_SLTI, OP_SLT, OP_CSRRS:                   f3 = 3'b010;
            OP_SLTIU, OP_SLTU, OP_CSRRC:                               f3 = 3'b011;
            OP_BLT, OP_LBU, OP_XORI, OP_XOR:                           f3 = 3'b100;
            OP_BGE, OP_LHU, OP_SRLI, OP_SRAI, OP_SRL, OP_SRA, OP_CSRRWI: f3 = 3'b101;
            OP_BLTU, OP_ORI, OP_OR, OP_CSRRSI:                         f3 = 3'b110;
            OP_BGEU, OP_ANDI, OP_AND, OP_CSRRCI:                       f3 = 3'b111;
            default:                                                   f3 = 3'b000;
        endcase
        if (op == OP_SRAI || op == OP_SUB || op == OP_SRA)
            f7 = 7'b0100000;
    end

    // Field placement; fields not used by a format stay zero.
    always_comb begin
        enc_word = raw;
        case (fmt)
            F_R:  enc_word = {f7, in_rs2, in_rs1, f3, in_rd, opc};
            F_I:  enc_word = {in_imm[11:0], in_rs1, f3, in_rd, opc};
            F_SH: enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
            F_S:  enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
            F_B:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                              in_imm[4:1], in_imm[11], opc};
            F_U:  enc_word = {in_imm[31:12], in_rd, opc};
            F_J:  enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
            default: enc_word = raw;
        endcase
    end

    // Ready only when the parcel path can take a new word without a bubble.
    assign in_ready = !rst && (state_q == S_IDLE || (state_q == S_HIGH && out_ready));
    assign acc      = in_valid && in_ready;

    // Next state and parcel outputs; everything reads zero while in reset.
    always_comb begin
        state_d    = state_q;
        out_valid  = 1'b0;
        out_parcel = 16'h0;
        out_last   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: if (acc && enc_legal) state_d = S_LOW;
                S_LOW: begin
                    out_valid  = 1'b1;
                    out_parcel = word_q[15:0];
                    if (out_ready) state_d = S_HIGH;
                end
                S_HIGH: begin
                    out_valid  = 1'b1;
                    out_parcel = word_q[31:16];
                    out_last   = 1'b1;
                    if (out_ready) state_d = (acc && enc_legal) ? S_LOW : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, captured word, error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            word_q  <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (acc && enc_legal)
                word_q <= enc_word;
            err_q <= acc && !enc_legal;
            if (acc && !enc_legal && cnt_q != '1)
                cnt_q <= cnt_q + ERR_COUNT_WIDTH'(1);
        end
    end

    assign err_valid = err_q && !rst;
    assign err_count = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Bench for rv_inst_encoder: directed cases plus randomized requests checked
// against a table-driven encoding model and a parcel scoreboard.
module tb_rv_inst_encoder;

    localparam logic [7:0] OP_LUI = 0, OP_AUIPC = 1, OP_JAL = 2, OP_JALR = 3;
    localparam logic [7:0] OP_BEQ = 4, OP_BGEU = 9, OP_LB = 10, OP_LHU = 14;
    localparam logic [7:0] OP_SB = 15, OP_SW = 17, OP_ADDI = 18, OP_ANDI = 23;
    localparam logic [7:0] OP_SLLI = 24, OP_SRAI = 26, OP_ADD = 27, OP_SUB = 28;
    localparam logic [7:0] OP_SRA = 34, OP_AND = 36, OP_FENCE = 37, OP_FENCE_I = 38;
    localparam logic [7:0] OP_ECALL = 39, OP_EBREAK = 40, OP_CSRRW = 41, OP_CSRRCI = 46;
    localparam logic [7:0] OP_UNDEF = 47;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_op = '0;
    logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic [3:0] in_pred = '0, in_succ = '0;
    logic in_ready, out_valid, out_last, err_valid;
    logic [15:0] out_parcel;
    logic [7:0] err_count;
    logic in_ready2, out_valid2, out_last2, err_valid2;
    logic [15:0] out_parcel2;
    logic [1:0] err_count2;

    int n_total = 0, n_bad = 0;
    int cyc = 0, acc_cyc = 0, errs_seen = 0, cnt = 0, cnt2 = 0;
    bit pend = 0, prev_stall = 0, rnd_rdy = 0;
    logic [16:0] exp_q[$];
    logic [16:0] seen[$];
    int hs_cyc[$];

    always #5 clk = ~clk;

    rv_inst_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_pred(in_pred), .in_succ(in_succ),
        .out_valid(out_valid), .out_ready(out_ready), .out_parcel(out_parcel),
        .out_last(out_last), .err_valid(err_valid), .err_count(err_count)
    );

    rv_inst_encoder #(.ERR_COUNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_pred(in_pred), .in_succ(in_succ),
        .out_valid(out_valid2), .out_ready(out_ready), .out_parcel(out_parcel2),
        .out_last(out_last2), .err_valid(err_valid2), .err_count(err_count2)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference encoder: {legal, word}, built from per-class tables.
    function automatic logic [32:0] ref_enc(logic [7:0] op, logic [4:0] rd, logic [4:0] rs1,
                                            logic [4:0] rs2, logic [31:0] imm,
                                            logic [3:0] pred, logic [3:0] succ);
        int bf3[6] = '{0, 1, 4, 5, 6, 7};
        int lf3[5] = '{0, 1, 2, 4, 5};
        int af3[6] = '{0, 2, 3, 4, 6, 7};
        int rf3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        int cf3[6] = '{1, 2, 3, 5, 6, 7};
        int si, opc, f3, f7;
        logic [31:0] w, vrd, vr1, vr2;
        bit ok;
        byte fmt;
        si = $signed(imm);
        vrd = 32'(rd); vr1 = 32'(rs1); vr2 = 32'(rs2);
        opc = 0; f3 = 0; f7 = 0; w = 0; ok = 1; fmt = "X";
        if (op == OP_LUI) begin fmt = "U"; opc = 55; end
        else if (op == OP_AUIPC) begin fmt = "U"; opc = 23; end
        else if (op == OP_JAL) begin fmt = "J"; opc = 111; end
        else if (op == OP_JALR) begin fmt = "I"; opc = 103; end
        else if (op >= OP_BEQ && op <= OP_BGEU) begin fmt = "B"; opc = 99; f3 = bf3[op - OP_BEQ]; end
        else if (op >= OP_LB && op <= OP_LHU) begin fmt = "I"; opc = 3; f3 = lf3[op - OP_LB]; end
        else if (op >= OP_SB && op <= OP_SW) begin fmt = "S"; opc = 35; f3 = int'(op - OP_SB); end
        else if (op >= OP_ADDI && op <= OP_ANDI) begin fmt = "I"; opc = 19; f3 = af3[op - OP_ADDI]; end
        else if (op >= OP_SLLI && op <= OP_SRAI) begin
            fmt = "H"; opc = 19; f3 = (op == OP_SLLI) ? 1 : 5; f7 = (op == OP_SRAI) ? 32 : 0;
        end
        else if (op >= OP_ADD && op <= OP_AND) begin
            fmt = "R"; opc = 51; f3 = rf3[op - OP_ADD]; f7 = (op == OP_SUB || op == OP_SRA) ? 32 : 0;
        end
        else if (op == OP_FENCE) begin fmt = "F"; w = 15 + (32'(pred) << 24) + (32'(succ) << 20); end
        else if (op == OP_FENCE_I) begin fmt = "F"; w = 32'h100F; end
        else if (op == OP_ECALL) begin fmt = "F"; w = 32'h73; end
        else if (op == OP_EBREAK) begin fmt = "F"; w = 32'h100073; end
        else if (op >= OP_CSRRW && op <= OP_CSRRCI) begin fmt = "C"; opc = 115; f3 = cf3[op - OP_CSRRW]; end
        case (fmt)
            "R": w = opc + (vrd << 7) + (f3 << 12) + (vr1 << 15) + (vr2 << 20) + (f7 << 25);
            "I": begin ok = si >= -2048 && si <= 2047;
                 w = opc + (vrd << 7) + (f3 << 12) + (vr1 << 15) + ((imm & 32'hFFF) << 20); end
            "C": begin ok = imm < 4096;
                 w = opc + (vrd << 7) + (f3 << 12) + (vr1 << 15) + (imm << 20); end
            "H": begin ok = imm < 32;
                 w = opc + (vrd << 7) + (f3 << 12) + (vr1 << 15) + (imm << 20) + (f7 << 25); end
            "S": begin ok = si >= -2048 && si <= 2047;
                 w = opc + ((imm & 31) << 7) + (f3 << 12) + (vr1 << 15) + (vr2 << 20)
                     + (((imm >> 5) & 127) << 25); end
            "B": begin ok = si >= -4096 && si <= 4095 && si % 2 == 0;
                 w = opc + (((imm >> 11) & 1) << 7) + (((imm >> 1) & 15) << 8) + (f3 << 12)
                     + (vr1 << 15) + (vr2 << 20) + (((imm >> 5) & 63) << 25)
                     + (((imm >> 12) & 1) << 31); end
            "U": begin ok = imm % 4096 == 0; w = imm + (vrd << 7) + opc; end
            "J": begin ok = si >= -(1 << 20) && si < (1 << 20) && si % 2 == 0;
                 w = opc + (vrd << 7) + (((imm >> 12) & 255) << 12) + (((imm >> 11) & 1) << 20)
                     + (((imm >> 1) & 1023) << 21) + (((imm >> 20) & 1) << 31); end
            "F": ok = 1;
            default: ok = 0;
        endcase
        return {ok, w};
    endfunction

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [32:0] r;
        cyc++;
        if (rst) begin
            chk("rst_ov", {31'b0, out_valid}, 0);
            chk("rst_rdy", {30'b0, in_ready, in_ready2}, 0);
            chk("rst_par", {15'b0, out_last, out_parcel}, 0);
            chk("rst_err", {31'b0, err_valid}, 0);
            chk("rst_cnt", {22'b0, err_count2, err_count}, 0);
            exp_q.delete();
            pend = 0; cnt = 0; cnt2 = 0; prev_stall = 0;
        end else begin
            chk("err_v", {30'b0, err_valid, err_valid2}, {30'b0, pend, pend});
            if (pend) begin
                errs_seen++;
                if (cnt < 255) cnt++;
                if (cnt2 < 3) cnt2++;
            end
            chk("err_cnt", 32'(err_count), cnt);
            chk("err_cnt2", 32'(err_count2), cnt2);
            if (prev_stall) chk("hold_v", {31'b0, out_valid}, 1);
            if (out_valid) begin
                chk("ov2", {31'b0, out_valid2}, 1);
                if (exp_q.size() == 0) chk("q_nonempty", 32'(exp_q.size()), 1);
                else begin
                    chk("parcel", {15'b0, out_last, out_parcel}, {15'b0, exp_q[0]});
                    chk("parcel2", {15'b0, out_last2, out_parcel2}, {15'b0, exp_q[0]});
                    if (!out_ready) chk("stall_rdy", {30'b0, in_ready, in_ready2}, 0);
                    else begin
                        seen.push_back({out_last, out_parcel});
                        hs_cyc.push_back(cyc);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            pend = 0;
            if (in_valid && in_ready) begin
                acc_cyc = cyc;
                r = ref_enc(in_op, in_rd, in_rs1, in_rs2, in_imm, in_pred, in_succ);
                if (r[32]) begin
                    exp_q.push_back({1'b0, r[15:0]});
                    exp_q.push_back({1'b1, r[31:16]});
                end else pend = 1;
            end
        end
    end

    task automatic send(logic [7:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                        logic [31:0] imm, logic [3:0] p = 4'h0, logic [3:0] s = 4'h0);
        int n = 0;
        in_valid = 1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_pred = p; in_succ = s;
        do begin @(negedge clk); n++; end while (!in_ready && n < 100);
        chk("send_to", {31'b0, n < 100}, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        do begin @(negedge clk); #1; n++; end while ((exp_q.size() != 0 || out_valid) && n < 300);
        chk("drain_to", {31'b0, n < 300}, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic exp_seen(string tag, int idx, logic [16:0] v);
        if (idx < seen.size()) chk(tag, {15'b0, seen[idx]}, {15'b0, v});
        else chk(tag, 32'(seen.size()), idx + 1);
    endtask

    task automatic clr();
        seen.delete();
        hs_cyc.delete();
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [31:0] imm;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("post_rst_rdy", {31'b0, in_ready}, 1);
        chk("post_rst_ov", {31'b0, out_valid}, 0);
        @(posedge clk); #1;

        // ADDI x1, x0, 5 and its latency
        out_ready = 1; clr();
        send(OP_ADDI, 1, 0, 0, 5); in_valid = 0; drain();
        exp_seen("addi_lo", 0, 17'h00093);
        exp_seen("addi_hi", 1, 17'h10050);
        if (hs_cyc.size() > 0) chk("addi_lat", hs_cyc[0] - acc_cyc, 1);

        // BEQ x1, x2, -4
        clr();
        send(OP_BEQ, 0, 1, 2, -4); in_valid = 0; drain();
        exp_seen("beq_lo", 0, 17'h08EE3);
        exp_seen("beq_hi", 1, 17'h1FE20);

        // LUI then SUB back to back: four parcels on consecutive cycles
        clr();
        send(OP_LUI, 5, 0, 0, 32'h12345000);
        send(OP_SUB, 3, 1, 2, 0); in_valid = 0; drain();
        exp_seen("b2b_0", 0, 17'h052B7);
        exp_seen("b2b_1", 1, 17'h11234);
        exp_seen("b2b_2", 2, 17'h081B3);
        exp_seen("b2b_3", 3, 17'h14020);
        if (hs_cyc.size() == 4) chk("b2b_span", hs_cyc[3] - hs_cyc[0], 3);
        else chk("b2b_hs", 32'(hs_cyc.size()), 4);

        // Illegal requests: odd JAL offset, out-of-range ADDI, undefined op
        clr(); e0 = errs_seen;
        send(OP_JAL, 1, 0, 0, 3);
        send(OP_ADDI, 1, 0, 0, 2048);
        send(OP_UNDEF, 0, 0, 0, 0); in_valid = 0; drain();
        chk("ill_nopar", 32'(seen.size()), 0);
        chk("ill_pulses", errs_seen - e0, 3);
        chk("ill_cnt", 32'(err_count), 3);
        send(OP_UNDEF + 8'd5, 0, 0, 0, 0); in_valid = 0; drain();
        chk("ill_cnt4", 32'(err_count), 4);
        chk("ill_sat2", 32'(err_count2), 3);

        // ECALL with the high parcel stalled for three cycles
        out_ready = 0; clr();
        send(OP_ECALL, 0, 0, 0, 0); in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1 out_ready = 0;
        repeat (3) begin
            @(negedge clk);
            chk("ec_stall", {14'b0, out_valid, in_ready, out_last, out_parcel}, {14'b0, 1'b1, 1'b0, 17'h10000});
        end
        @(posedge clk); #1 out_ready = 1;
        drain();
        exp_seen("ec_lo", 0, 17'h00073);
        exp_seen("ec_hi", 1, 17'h10000);

        // Reset while SRAI sits in LOW; the word must be discarded
        out_ready = 0; clr();
        send(OP_SRAI, 2, 2, 0, 4); in_valid = 0;
        @(negedge clk);
        chk("srai_lo", {15'b0, out_valid, out_parcel}, {15'b0, 1'b1, 16'h5113});
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_mid", {30'b0, out_valid, in_ready}, {30'b0, 1'b0, 1'b1});
        @(posedge clk); #1 out_ready = 1; clr();
        send(OP_ADDI, 1, 0, 0, 5); in_valid = 0; drain();
        chk("rst_n", 32'(seen.size()), 2);
        exp_seen("rst_lo", 0, 17'h00093);
        exp_seen("rst_hi", 1, 17'h10050);

        // Randomized requests with random backpressure
        rnd_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: imm = $urandom;
                1: imm = $urandom_range(0, 8191) - 4096;
                2: imm = $urandom_range(0, 40);
                3: imm = $urandom & 32'hFFFFF000;
                default: imm = ($urandom_range(0, (1 << 21) - 1) - (1 << 20)) & ~32'd1;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 0;
                @(posedge clk); #1;
            end
            send(8'($urandom_range(0, 52)), 5'($urandom), 5'($urandom), 5'($urandom), imm,
                 4'($urandom), 4'($urandom));
        end
        in_valid = 0;
        rnd_rdy = 0; out_ready = 1;
        drain();
        chk("final_q", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
